// File: rtl/control_unit.sv
// control_unit: Moore FSM that fetches, decodes and sequences the six-instruction 16-bit datapath.
// Latency: 3 cycles per instruction (fetch, decode, execute); a taken JMPZ adds one PC-update cycle.
// Backpressure: none; all memories answer in one cycle, an illegal opcode halts until reset.
module control_unit #(
   parameter int WIDTH   = 16,
   parameter int REGBITS = 4,
   parameter int DADDR   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   i_data,
   output logic [WIDTH-1:0]   i_addr,
   output logic               i_rd,
   output logic [DADDR-1:0]   d_addr,
   output logic               d_rd,
   output logic               d_wr,
   output logic [7:0]         rf_w_data,
   output logic [REGBITS-1:0] rf_w_addr,
   output logic [REGBITS-1:0] rf_rp_addr,
   output logic [REGBITS-1:0] rf_rq_addr,
   output logic               rf_w_wr,
   output logic               rf_rp_rd,
   output logic               rf_rq_rd,
   output logic [1:0]         rf_s,
   output logic [1:0]         alu_s,
   input  logic               rf_rp_zero,
   output logic               halt
);

   // State encoding kept as plain constants so it matches older netlists and waveforms
   localparam logic [3:0] S_INIT      = 4'd0;
   localparam logic [3:0] S_FETCH     = 4'd1;
   localparam logic [3:0] S_DECODE    = 4'd2;
   localparam logic [3:0] S_LOAD      = 4'd3;
   localparam logic [3:0] S_STORE     = 4'd4;
   localparam logic [3:0] S_ADD       = 4'd5;
   localparam logic [3:0] S_SUB       = 4'd6;
   localparam logic [3:0] S_LOADC     = 4'd7;
   localparam logic [3:0] S_JMPZ      = 4'd8;
   localparam logic [3:0] S_JMPZ_TAKE = 4'd9;
   localparam logic [3:0] S_ILLEGAL   = 4'd10;

   localparam logic [3:0] OP_LOAD  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_LOADC = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_JMPZ  = 4'b0101;

   localparam logic [1:0] RF_S_ALU = 2'b00;
   localparam logic [1:0] RF_S_MEM = 2'b01;
   localparam logic [1:0] RF_S_IMM = 2'b10;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   logic [3:0]       state;
   logic [3:0]       state_nxt;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ir;

   // Instruction fields
   logic [3:0]       opcode;
   logic [3:0]       ra;
   logic [3:0]       rb;
   logic [3:0]       rc;
   logic [7:0]       d;
   logic [WIDTH-1:0] d_sext;

   assign opcode = ir[15:12];
   assign ra     = ir[11:8];
   assign rb     = ir[7:4];
   assign rc     = ir[3:0];
   assign d      = ir[7:0];
   assign d_sext = {{(WIDTH-8){d[7]}}, d};

   // Instruction memory always addressed by the PC, including during reset
   assign i_addr = pc;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_INIT;
      end else begin
         state <= state_nxt;
      end
   end

   // PC and IR: load on fetch, relative branch when JMPZ is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= '0;
         ir <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               ir <= i_data;
               pc <= pc + WIDTH'(1);
            end
            // PC already points one past the JMPZ, so back off by one to land on jmpz_addr + d
            S_JMPZ_TAKE: pc <= pc + d_sext - WIDTH'(1);
            default: ;
         endcase
      end
   end

   // Next-state logic: decode dispatch, zero-flag branch resolution, ILLEGAL is a sink
   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT:   state_nxt = S_FETCH;
         S_FETCH:  state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD:  state_nxt = S_LOAD;
               OP_STORE: state_nxt = S_STORE;
               OP_ADD:   state_nxt = S_ADD;
               OP_LOADC: state_nxt = S_LOADC;
               OP_SUB:   state_nxt = S_SUB;
               OP_JMPZ:  state_nxt = S_JMPZ;
               default:  state_nxt = S_ILLEGAL;
            endcase
         end
         S_LOAD, S_STORE, S_ADD, S_SUB, S_LOADC: state_nxt = S_FETCH;
         S_JMPZ:      state_nxt = rf_rp_zero ? S_JMPZ_TAKE : S_FETCH;
         S_JMPZ_TAKE: state_nxt = S_FETCH;
         S_ILLEGAL:   state_nxt = S_ILLEGAL;
         // Unused encodings park in ILLEGAL so a corrupted state is visible on halt
         default:     state_nxt = S_ILLEGAL;
      endcase
   end

   // Moore output decode from state and IR; everything not driven by a state stays 0
   always_comb begin
      i_rd       = 1'b0;
      d_addr     = '0;
      d_rd       = 1'b0;
      d_wr       = 1'b0;
      rf_w_data  = 8'h00;
      rf_w_addr  = '0;
      rf_rp_addr = '0;
      rf_rq_addr = '0;
      rf_w_wr    = 1'b0;
      rf_rp_rd   = 1'b0;
      rf_rq_rd   = 1'b0;
      rf_s       = RF_S_ALU;
      alu_s      = ALU_PASS;
      halt       = 1'b0;
      case (state)
         S_FETCH: i_rd = 1'b1;
         S_LOAD: begin
            d_addr    = DADDR'(d);
            d_rd      = 1'b1;
            rf_s      = RF_S_MEM;
            rf_w_addr = REGBITS'(ra);
            rf_w_wr   = 1'b1;
         end
         S_STORE: begin
            d_addr     = DADDR'(d);
            d_wr       = 1'b1;
            rf_rp_addr = REGBITS'(ra);
            rf_rp_rd   = 1'b1;
         end
         S_ADD, S_SUB: begin
            rf_rp_addr = REGBITS'(rb);
            rf_rp_rd   = 1'b1;
            rf_rq_addr = REGBITS'(rc);
            rf_rq_rd   = 1'b1;
            alu_s      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
            rf_s       = RF_S_ALU;
            rf_w_addr  = REGBITS'(ra);
            rf_w_wr    = 1'b1;
         end
         S_LOADC: begin
            rf_s      = RF_S_IMM;
            rf_w_data = d;
            rf_w_addr = REGBITS'(ra);
            rf_w_wr   = 1'b1;
         end
         S_JMPZ: begin
            rf_rp_addr = REGBITS'(ra);
            rf_rp_rd   = 1'b1;
         end
         S_ILLEGAL: halt = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Moore FSM controller that sequences the 16-bit six-instruction processor datapath (register bank, ALU, write-data mux, data memory).
- Holds the program counter (PC) and instruction register (IR).
- Fetches instructions from instruction memory, decodes them, and drives all register-file, ALU, mux and data-memory control lines.
- Receives the rf_rp_zero flag back from the datapath to resolve conditional jumps.

Parameters:
- WIDTH, 16, instruction and PC width.
- REGBITS, 4, register address width.
- DADDR, 8, data-memory address width.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_data  input  WIDTH  instruction word read at i_addr (combinational read).
- i_addr  output  WIDTH  instruction address, always equal to PC.
- i_rd  output  1  instruction memory read enable.
- d_addr  output  DADDR  data memory address.
- d_rd  output  1  data memory read enable.
- d_wr  output  1  data memory write enable.
- rf_w_data  output  8  immediate constant to the write-data mux.
- rf_w_addr, rf_rp_addr, rf_rq_addr  output  REGBITS  register-file addresses.
- rf_w_wr, rf_rp_rd, rf_rq_rd  output  1  register-file enables.
- rf_s  output  2  write-data mux select: 00 ALU, 01 data memory, 10 immediate.
- alu_s  output  2  ALU operation: 00 bypass, 01 add, 10 sub.
- rf_rp_zero  input  1  Rp-port zero flag from the datapath.
- halt  output  1  high while in ILLEGAL.

Behaviour:
- Encoding:
  - IR[15:12] opcode, IR[11:8] ra, IR[7:4] rb, IR[3:0] rc.
  - IR[7:0] is d, the constant or the offset, depending on opcode.
  - Opcodes: 0000 LOAD, 0001 STORE, 0010 ADD, 0011 LOADC, 0100 SUB, 0101 JMPZ; 0110–1111 illegal.
- Reset (async, rst_n=0):
  - State=INIT, PC=0, IR=0.
  - All outputs 0, except i_addr, which follows PC=0.
  - Reset asserted mid-instruction aborts it immediately; no further write is issued.
- Outputs:
  - Outputs are decoded combinationally from state and IR only (Moore).
  - Every output not listed for a state is 0; address outputs default to 0.
- States and transitions:
  - INIT: no outputs → FETCH.
  - FETCH: i_rd=1; IR<=i_data; PC<=PC+1 (wraps at 2^WIDTH) → DECODE.
  - DECODE: no outputs → state selected by IR[15:12]; illegal opcode → ILLEGAL.
  - LOAD: d_addr=d, d_rd=1, rf_s=01, rf_w_addr=ra, rf_w_wr=1 → FETCH.
  - STORE: d_addr=d, d_wr=1, rf_rp_addr=ra, rf_rp_rd=1 → FETCH.
  - ADD: rf_rp_addr=rb, rf_rp_rd=1, rf_rq_addr=rc, rf_rq_rd=1, alu_s=01, rf_s=00, rf_w_addr=ra, rf_w_wr=1 → FETCH.
  - SUB: same as ADD but alu_s=10 (ra=rb−rc) → FETCH.
  - LOADC: rf_s=10, rf_w_data=d, rf_w_addr=ra, rf_w_wr=1 → FETCH.
  - JMPZ: rf_rp_addr=ra, rf_rp_rd=1; rf_rp_zero=1 → JMPZ_TAKE, else → FETCH.
  - JMPZ_TAKE: PC<=PC+signext(d)−1 (modulo 2^WIDTH; target = address of JMPZ + offset) → FETCH.
  - ILLEGAL: halt=1, all other outputs 0, PC/IR frozen; exits only by reset.
- Latency:
  - LOAD/STORE/ADD/SUB/LOADC: 3 cycles each.
  - JMPZ: 3 cycles not taken, 4 cycles taken.
- Boundaries:
  - Offset 0x00 jumps to itself (infinite loop, legal).
  - PC at 0xFFFF fetch wraps to 0x0000.
  - Write address equal to a read address in ADD/SUB is legal; the register updates at the end of the cycle.

Test Plan:
- Reset: hold rst_n=0 across several edges, release → INIT, FETCH with i_addr=0x0000, i_rd=1; all other outputs 0 during reset.
- Program 0x3205 (LOADC r2,5), 0x3303 (LOADC r3,3), 0x2123 (ADD r1,r2,r3), 0x4423 (SUB r4,r2,r3) → r1=8, r4=2; 12 cycles after INIT; rf_s/alu_s checked per state.
- Program 0x0510 (LOAD r5,[0x10]) with mem[0x10]=0xBEEF, then 0x1520 (STORE [0x20],r5) → mem[0x20]=0xBEEF; d_rd pulse in LOAD, d_wr pulse in STORE, d_addr=0x10 then 0x20.
- JMPZ at PC=4 with 0x56FE (offset −2): with r6=0 → next fetch i_addr=0x0002 after 4 cycles; with r6≠0 → next fetch i_addr=0x0005 after 3 cycles.
- Fetch of 0x7000 → halt=1 from the cycle after DECODE, PC frozen at 1, no enables asserted; rst_n pulse clears halt.
- Assert rst_n=0 during the ADD state → rf_w_wr drops immediately, destination register unchanged, PC=0.
